flash_sample_player: RTL and testbench
======================================

Name: flash_sample_player

Overview:
Parametrised flash-to-codec sample player, the successor to the fixed-rate chipmunk playback path. It streams packed signed samples from the on-board flash (Avalon-MM read master) to the audio codec write interface. Playback rate is set by a fixed-point phase-step, so 1.0 is normal, 2.0 is chipmunk and 0.5 is slow, with fractional rates in between. It supports mono or stereo packing, a volume attenuation shift, one-shot or loop mode, and start/busy/done control.

Parameters:
SAMPLE_W, 16, sample width; two samples are packed per 32-bit flash word
ADDR_W, 23, flash word-address width
FRAC_W, 8, fractional bits of the rate step
INT_W, 4, integer bits of the rate step
STEREO, 0, 0: mono, low half played first; 1: each word is {right[31:16], left[15:0]}
CNT_W, 24, width of the sample counter

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins playback when idle, ignored while busy
loop_en  in  1  1: wrap to frame 0 at end; 0: stop
base_addr  in  ADDR_W  first flash word address, latched on start
num_frames  in  CNT_W  frames to play (a frame is one mono sample or one L/R pair), latched on start
step  in  INT_W+FRAC_W  rate in unsigned Q(INT_W.FRAC_W), sampled at every advance
atten  in  4  arithmetic right shift applied to each sample, 0..15
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when one-shot playback finishes
flash_mem_read  out  1  Avalon read request
flash_mem_address  out  ADDR_W  Avalon word address
flash_mem_byteenable  out  4  constant 4'b1111
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdata  in  32  Avalon read data
flash_mem_readdatavalid  in  1  Avalon data strobe
write_ready  in  1  codec can accept a sample
write_s  out  1  codec write strobe
writedata_left  out  SAMPLE_W  left sample to codec
writedata_right  out  SAMPLE_W  right sample to codec

Behaviour:
- Reset values: all outputs are 0, except flash_mem_byteenable, which is 4'b1111. The state machine returns to IDLE and the word cache is invalidated. Reset mid-transaction drops flash_mem_read in the next cycle; a late readdatavalid after reset is ignored.
- Phase accumulator: pos has CNT_W+FRAC_W bits; frame index n = pos[CNT_W+FRAC_W-1:FRAC_W].
- Word index: w = n>>1 in mono, w = n in stereo.
- Flash address: base_addr + w, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- Word cache: one cached 32-bit word plus its word index and a valid bit. A flash read occurs only on a cache miss.
- States and transitions:
  - IDLE: on start, latch base_addr and num_frames; if num_frames == 0, pulse done and stay in IDLE; otherwise pos = 0 and go to CHECK.
  - CHECK: if n >= num_frames: with loop_en, set pos = 0 and re-enter CHECK; without loop_en, pulse done and go to IDLE. Otherwise, a cache hit goes to WAIT_RDY and a miss goes to FETCH.
  - FETCH: assert flash_mem_read with the address until a cycle where waitrequest == 0, then go to FLWAIT. flash_mem_read and flash_mem_address stay stable while waitrequest is high.
  - FLWAIT: on readdatavalid, load the cache, set valid, go to WAIT_RDY.
  - WAIT_RDY: when write_ready == 1, drive the sample data and write_s = 1, then go to WAIT_ACC.
  - WAIT_ACC: hold write_s and the data until write_ready == 0, then drop write_s and go to ADVANCE.
  - ADVANCE: pos += step, with the step sampled this cycle; go to CHECK.
- Sample select, mono: the half selected by n[0] (0 = [15:0], 1 = [31:16]) goes to both channels.
- Sample select, stereo: [15:0] goes to left and [31:16] goes to right.
- Each sample is arithmetic-shifted right by atten, sampled when write_s is asserted, and sign-extended.
- Rate arithmetic:
  - step = 0 repeats the same frame indefinitely; this is legal, and no re-fetch occurs.
  - step > 1.0 skips frames; only the word holding the next played frame is fetched.
  - pos overflow is impossible for n < num_frames; num_frames must be <= 2^CNT_W - 2^INT_W, and the bench respects this.
- start while busy is ignored. loop_en is sampled at each end-of-buffer check.
- Throughput: at most one codec write per write_ready rising cycle; no other bandwidth guarantee.

Decomposition:
- Package flash_player_pkg: the state enum (IDLE, CHECK, FETCH, FLWAIT, WAIT_RDY, WAIT_ACC, ADVANCE), a sample_t typedef, and constant BYTEEN_ALL = 4'b1111.
- Sub-module flash_word_fetcher: owns FETCH/FLWAIT, the Avalon handshake and the one-word cache. It presents a req/hit/ready interface to the top FSM.

Test Plan:
1. Mono, step 1.0 (0x100), base 0, num_frames 4; flash words {0x2222,0x1111}, {0x4444,0x3333} -> codec receives 0x1111, 0x2222, 0x3333, 0x4444 on both channels; exactly 2 flash reads; done pulse; busy drops.
2. Mono, step 2.0, num_frames 8 -> frames 0, 2, 4, 6 played (all low halves); 4 flash reads. Step 0.5 -> each frame played twice; no repeated fetch.
3. Stereo, step 1.0, word 0x8000_7FFF, atten 4 -> left 0x07FF, right 0xF800.
4. Flash waitrequest held high for 5 cycles and readdatavalid delayed by 3 cycles -> address and read stay stable; data correct; no duplicate request.
5. loop_en = 1, num_frames 3 -> frame sequence 0, 1, 2, 0, 1, 2…; no done. Deassert loop_en -> done after the next frame 2.
6. Reset asserted in FLWAIT; stale readdatavalid arrives afterwards -> all outputs return to reset values; stale data ignored. A fresh start fetches again. num_frames 0 -> done on the cycle after start, no flash read.

Source files
------------

// File: rtl/flash_player_pkg.sv
// Shared types and constants for the flash sample player and its word fetcher.
package flash_player_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    FETCH    = 3'd2,
    FLWAIT   = 3'd3,
    WAIT_RDY = 3'd4,
    WAIT_ACC = 3'd5,
    ADVANCE  = 3'd6
  } state_e;

  typedef logic signed [15:0] sample_t;

  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  function automatic sample_t attenuate(input sample_t s, input logic [3:0] sh);
    return s >>> sh;
  endfunction

endpackage

// File: rtl/flash_word_fetcher.sv
// Avalon-MM read master plus a one-word cache tagged by word index.
// ready is combinational so the cache is already valid when the caller moves on.
module flash_word_fetcher
  import flash_player_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int IDX_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic [ADDR_W-1:0] base,
  output logic              hit,
  output logic              accepted,
  output logic              ready,
  output logic [31:0]       word,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid
);

  logic             valid;
  logic             pending;
  logic [IDX_W-1:0] tag;
  logic [IDX_W-1:0] pend_tag;

  assign flash_mem_byteenable = BYTEEN_ALL;
  assign accepted = flash_mem_read && !flash_mem_waitrequest;
  // Only a read we issued and has not yet returned may load the cache;
  // this also discards data that straggles in after a reset.
  assign ready = pending && flash_mem_readdatavalid;
  assign hit   = valid && (tag == idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      pending           <= 1'b0;
      valid             <= 1'b0;
      tag               <= '0;
      pend_tag          <= '0;
      word              <= '0;
    end else begin
      if (flush) valid <= 1'b0;
      if (req) begin
        flash_mem_read    <= 1'b1;
        flash_mem_address <= base + ADDR_W'(idx);
        pend_tag          <= idx;
      end else if (accepted) begin
        flash_mem_read <= 1'b0;
        pending        <= 1'b1;
      end
      if (ready) begin
        word    <= flash_mem_readdata;
        tag     <= pend_tag;
        valid   <= 1'b1;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/flash_sample_player.sv
// Streams packed samples from flash to the codec at a fixed-point playback rate.
// state    | meaning
// IDLE     | waiting for start
// CHECK    | end-of-buffer test, cache lookup
// FETCH    | flash read request outstanding (waitrequest)
// FLWAIT   | waiting for readdatavalid
// WAIT_RDY | waiting for codec write_ready
// WAIT_ACC | holding write_s until write_ready drops
// ADVANCE  | pos += step
module flash_sample_player
  import flash_player_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 23,
  parameter int FRAC_W   = 8,
  parameter int INT_W    = 4,
  parameter int STEREO   = 0,
  parameter int CNT_W    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        num_frames,
  input  logic [INT_W+FRAC_W-1:0] step,
  input  logic [3:0]              atten,
  output logic                    busy,
  output logic                    done,
  output logic                    flash_mem_read,
  output logic [ADDR_W-1:0]       flash_mem_address,
  output logic [3:0]              flash_mem_byteenable,
  input  logic                    flash_mem_waitrequest,
  input  logic [31:0]             flash_mem_readdata,
  input  logic                    flash_mem_readdatavalid,
  input  logic                    write_ready,
  output logic                    write_s,
  output logic [SAMPLE_W-1:0]     writedata_left,
  output logic [SAMPLE_W-1:0]     writedata_right
);

  localparam int POS_W = CNT_W + FRAC_W;

  state_e            state;
  logic [POS_W-1:0]  pos;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  frame;
  logic [CNT_W-1:0]  word_idx;
  logic              hit;
  logic              accepted;
  logic              ready;
  logic              fetch_req;
  logic              flush;
  logic [31:0]       word;
  sample_t           raw_left;
  sample_t           raw_right;

  assign frame     = pos[POS_W-1:FRAC_W];
  assign word_idx  = (STEREO != 0) ? frame : (frame >> 1);
  // A new buffer may live at a different base, so the cache is dropped on start.
  assign flush     = (state == IDLE) && start;
  assign fetch_req = (state == CHECK) && (frame < num_q) && !hit;

  always_comb begin
    if (STEREO != 0) begin
      raw_left  = word[15:0];
      raw_right = word[31:16];
    end else begin
      raw_left  = frame[0] ? word[31:16] : word[15:0];
      raw_right = raw_left;
    end
  end

  flash_word_fetcher #(
    .ADDR_W (ADDR_W),
    .IDX_W  (CNT_W)
  ) u_fetcher (
    .clk                     (clk),
    .reset                   (reset),
    .flush                   (flush),
    .req                     (fetch_req),
    .idx                     (word_idx),
    .base                    (base_q),
    .hit                     (hit),
    .accepted                (accepted),
    .ready                   (ready),
    .word                    (word),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pos             <= '0;
      base_q          <= '0;
      num_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      write_s         <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_frames;
            if (num_frames == '0) begin
              done <= 1'b1;
            end else begin
              pos   <= '0;
              busy  <= 1'b1;
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (frame >= num_q) begin
            if (loop_en) begin
              pos <= '0;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (hit) begin
            state <= WAIT_RDY;
          end else begin
            state <= FETCH;
          end
        end
        FETCH:  if (accepted) state <= FLWAIT;
        FLWAIT: if (ready)    state <= WAIT_RDY;
        WAIT_RDY: begin
          if (write_ready) begin
            write_s         <= 1'b1;
            writedata_left  <= SAMPLE_W'(attenuate(raw_left, atten));
            writedata_right <= SAMPLE_W'(attenuate(raw_right, atten));
            state           <= WAIT_ACC;
          end
        end
        WAIT_ACC: begin
          if (!write_ready) begin
            write_s <= 1'b0;
            state   <= ADVANCE;
          end
        end
        ADVANCE: begin
          pos   <= pos + POS_W'(step);
          state <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_player.sv
// Bench for flash_sample_player: mono and stereo instances against a flash slave,
// a handshaking codec model and a frame-list reference model.
module tb_flash_sample_player;

  localparam int SW = 16, AW = 23, FW = 8, IW = 4, CW = 24;
  localparam int ONE = 1 << FW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              loop_en;
  logic [AW-1:0]     base_addr;
  logic [CW-1:0]     num_frames;
  logic [IW+FW-1:0]  step;
  logic [3:0]        atten;

  logic          start [2];
  logic          busy  [2];
  logic          done  [2];
  logic          rd    [2];
  logic [AW-1:0] addr  [2];
  logic [3:0]    be    [2];
  logic          wreq  [2];
  logic [31:0]   rdata [2];
  logic          rdv   [2];
  logic          wready[2];
  logic          ws    [2];
  logic [SW-1:0] wl    [2];
  logic [SW-1:0] wr    [2];

  logic [31:0]   mem [256];
  logic [31:0]   cap_q [2][$];
  logic [AW-1:0] acc_q [2][$];
  int            exp_f [$];

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cfg = -1;
  int lat_cfg = -1;

  flash_sample_player #(.SAMPLE_W(SW), .ADDR_W(AW), .FRAC_W(FW), .INT_W(IW), .STEREO(0), .CNT_W(CW)) dut_mono (
    .clk(clk), .reset(reset), .start(start[0]), .loop_en(loop_en), .base_addr(base_addr),
    .num_frames(num_frames), .step(step), .atten(atten), .busy(busy[0]), .done(done[0]),
    .flash_mem_read(rd[0]), .flash_mem_address(addr[0]), .flash_mem_byteenable(be[0]),
    .flash_mem_waitrequest(wreq[0]), .flash_mem_readdata(rdata[0]), .flash_mem_readdatavalid(rdv[0]),
    .write_ready(wready[0]), .write_s(ws[0]), .writedata_left(wl[0]), .writedata_right(wr[0]));

  flash_sample_player #(.SAMPLE_W(SW), .ADDR_W(AW), .FRAC_W(FW), .INT_W(IW), .STEREO(1), .CNT_W(CW)) dut_stereo (
    .clk(clk), .reset(reset), .start(start[1]), .loop_en(loop_en), .base_addr(base_addr),
    .num_frames(num_frames), .step(step), .atten(atten), .busy(busy[1]), .done(done[1]),
    .flash_mem_read(rd[1]), .flash_mem_address(addr[1]), .flash_mem_byteenable(be[1]),
    .flash_mem_waitrequest(wreq[1]), .flash_mem_readdata(rdata[1]), .flash_mem_readdatavalid(rdv[1]),
    .write_ready(wready[1]), .write_s(ws[1]), .writedata_left(wl[1]), .writedata_right(wr[1]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flash slave: one outstanding read, configurable stall and return latency.
  initial begin
    int       stall_left [2];
    int       delay [2];
    bit       pend [2];
    bit       stalled [2];
    logic [AW-1:0] p_addr [2];
    logic [AW-1:0] last_addr [2];
    for (int g = 0; g < 2; g++) begin
      wreq[g] = 1'b0; rdv[g] = 1'b0; rdata[g] = '0;
      stall_left[g] = 0; delay[g] = 0; pend[g] = 1'b0; stalled[g] = 1'b0;
      p_addr[g] = '0; last_addr[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        rdv[g] = 1'b0;
        if (pend[g]) begin
          if (delay[g] == 0) begin
            rdv[g] = 1'b1;
            rdata[g] = mem[p_addr[g][7:0]];
            pend[g] = 1'b0;
          end else delay[g]--;
        end
        if (!reset && rd[g]) begin
          if (stalled[g]) check_val("rd_addr_stable", 32'(addr[g]), 32'(last_addr[g]));
          else stall_left[g] = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
          if (stall_left[g] > 0) begin
            wreq[g] = 1'b1;
            stall_left[g]--;
            stalled[g] = 1'b1;
            last_addr[g] = addr[g];
          end else begin
            wreq[g] = 1'b0;
            stalled[g] = 1'b0;
            acc_q[g].push_back(addr[g]);
            pend[g] = 1'b1;
            p_addr[g] = addr[g];
            delay[g] = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
          end
        end else begin
          if (!reset && stalled[g]) check_val("rd_held_in_stall", 32'(rd[g]), 32'd1);
          wreq[g] = 1'b0;
          stalled[g] = 1'b0;
        end
      end
    end
  end

  // Codec: raise ready, capture one write, hold, drop ready, wait for write_s to fall.
  initial begin
    int          ph [2];
    int          cnt [2];
    logic [31:0] held [2];
    for (int g = 0; g < 2; g++) begin
      wready[g] = 1'b0; ph[g] = 0; cnt[g] = 2; held[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        case (ph[g])
          0: begin
            if (!reset) check_val("ws_while_not_ready", 32'(ws[g]), 32'd0);
            if (cnt[g] == 0) begin wready[g] = 1'b1; ph[g] = 1; end
            else cnt[g]--;
          end
          1: begin
            if (!reset && ws[g]) begin
              held[g] = {wl[g], wr[g]};
              cap_q[g].push_back(held[g]);
              cnt[g] = $urandom_range(0, 3);
              ph[g] = 2;
            end
          end
          2: begin
            if (reset) ph[g] = 3;
            else begin
              check_val("ws_hold", 32'(ws[g]), 32'd1);
              check_val("wdata_hold", {wl[g], wr[g]}, held[g]);
              if (cnt[g] == 0) begin wready[g] = 1'b0; ph[g] = 3; end
              else cnt[g]--;
            end
          end
          default: begin
            wready[g] = 1'b0;
            if (!ws[g]) begin cnt[g] = $urandom_range(0, 4); ph[g] = 0; end
          end
        endcase
      end
    end
  end

  // Reference frame list: single pass (want == 0) or wrapping until `want` frames.
  task automatic gen_frames(input int num, input int stp, input int want);
    longint p;
    p = 0;
    exp_f.delete();
    forever begin
      if (p / ONE >= num) begin
        if (want == 0 || exp_f.size() >= want) break;
        p = 0;
      end else begin
        if (want > 0 && exp_f.size() >= want) break;
        exp_f.push_back(int'(p / ONE));
        p += stp;
      end
    end
  endtask

  task automatic check_run(input int g, input int bse, input int att);
    int            last_w;
    int            w;
    int            sl;
    int            sr;
    logic [31:0]   word;
    logic [AW-1:0] a;
    logic [AW-1:0] exp_a [$];
    logic [31:0]   expv;
    last_w = -1;
    check_val("n_writes", 32'(cap_q[g].size()), 32'(exp_f.size()));
    foreach (exp_f[i]) begin
      w = (g == 1) ? exp_f[i] : exp_f[i] / 2;
      a = AW'(bse + w);
      if (w != last_w) begin exp_a.push_back(a); last_w = w; end
      word = mem[a[7:0]];
      if (g == 1) begin
        sl = int'($signed(word[15:0]));
        sr = int'($signed(word[31:16]));
      end else begin
        sl = (exp_f[i] % 2 == 1) ? int'($signed(word[31:16])) : int'($signed(word[15:0]));
        sr = sl;
      end
      sl = sl >>> att;
      sr = sr >>> att;
      expv = {sl[15:0], sr[15:0]};
      if (i < cap_q[g].size()) check_val("sample", cap_q[g][i], expv);
    end
    check_val("n_flash_reads", 32'(acc_q[g].size()), 32'(exp_a.size()));
    foreach (exp_a[i])
      if (i < acc_q[g].size()) check_val("flash_addr", 32'(acc_q[g][i]), 32'(exp_a[i]));
  endtask

  task automatic setup(input int bse, input int num, input int stp, input int att, input logic lp);
    base_addr = AW'(bse);
    num_frames = CW'(num);
    step = (IW+FW)'(stp);
    atten = 4'(att);
    loop_en = lp;
    for (int g = 0; g < 2; g++) begin cap_q[g].delete(); acc_q[g].delete(); end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int bound);
    int cyc;
    cyc = 0;
    while (!done[g] && cyc < bound) begin @(negedge clk); cyc++; end
    check_val("done_seen", 32'(done[g]), 32'd1);
    @(negedge clk);
    check_val("done_is_pulse", 32'(done[g]), 32'd0);
    check_val("busy_after_done", 32'(busy[g]), 32'd0);
  endtask

  task automatic play(input int g, input int bse, input int num, input int stp, input int att);
    setup(bse, num, stp, att, 1'b0);
    pulse_start(g);
    if (num == 0) begin
      check_val("zero_done_next_cycle", 32'(done[g]), 32'd1);
      check_val("zero_busy", 32'(busy[g]), 32'd0);
    end else begin
      check_val("busy_after_start", 32'(busy[g]), 32'd1);
    end
    gen_frames(num, stp, 0);
    wait_done(g, exp_f.size() * 60 + 200);
    check_run(g, bse, att);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_val({tag, "_read"}, 32'(rd[g]), 32'd0);
      check_val({tag, "_addr"}, 32'(addr[g]), 32'd0);
      check_val({tag, "_byteen"}, 32'(be[g]), 32'hF);
      check_val({tag, "_ws"}, 32'(ws[g]), 32'd0);
      check_val({tag, "_wdata"}, {wl[g], wr[g]}, 32'd0);
      check_val({tag, "_busy_done"}, {30'd0, busy[g], done[g]}, 32'd0);
    end
  endtask

  initial begin
    int cyc;
    int n;
    int g;
    int bse;
    int att;
    bit early_done;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) start[i] = 1'b0;
    setup(0, 0, ONE, 0, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Basic mono playback at 1.0.
    mem[0] = 32'h2222_1111;
    mem[1] = 32'h4444_3333;
    play(0, 0, 4, 'h100, 0);
    check_val("t1_first", cap_q[0][0], 32'h1111_1111);
    check_val("t1_last", cap_q[0][3], 32'h4444_4444);
    check_val("t1_reads", 32'(acc_q[0].size()), 32'd2);

    // Chipmunk and slow rates.
    play(0, 8, 8, 'h200, 0);
    play(0, 8, 4, 'h080, 0);
    check_val("half_rate_reads", 32'(acc_q[0].size()), 32'd2);

    // Stereo with attenuation.
    mem[5] = 32'h8000_7FFF;
    play(1, 5, 1, 'h100, 4);
    check_val("stereo_pair", cap_q[1][0], 32'h07FF_F800);

    // Long stall and slow return.
    stall_cfg = 5;
    lat_cfg = 3;
    play(0, 'h20, 4, 'h100, 1);
    play(1, 'h24, 2, 'h100, 0);
    stall_cfg = -1;
    lat_cfg = -1;

    // Loop mode, released after the seventh write.
    att = $urandom_range(0, 15);
    setup('h40, 3, 'h100, att, 1'b1);
    pulse_start(0);
    cyc = 0;
    early_done = 1'b0;
    while (cap_q[0].size() < 7 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done[0]) early_done = 1'b1;
    end
    check_val("loop_no_done", 32'(early_done), 32'd0);
    loop_en = 1'b0;
    wait_done(0, 1000);
    check_val("loop_len", 32'(cap_q[0].size()), 32'd9);
    gen_frames(3, 'h100, 9);
    check_run(0, 'h40, att);

    // Step 0 repeats frame 0 without refetching; stopped by reset.
    setup('h30, 2, 0, 0, 1'b0);
    pulse_start(0);
    cyc = 0;
    while (cap_q[0].size() < 4 && cyc < 1000) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_f.delete();
    for (int i = 0; i < 4; i++) exp_f.push_back(0);
    check_run(0, 'h30, 0);

    // Reset while waiting for read data; the late beat must be ignored.
    stall_cfg = 0;
    lat_cfg = 6;
    setup('h50, 2, 'h100, 0, 1'b0);
    pulse_start(0);
    cyc = 0;
    while (acc_q[0].size() == 0 && cyc < 200) begin @(negedge clk); cyc++; end
    check_val("rst_test_read_issued", 32'(acc_q[0].size()), 32'd1);
    @(negedge clk);
    pulse_reset();
    check_reset_values("mid_reset");
    repeat (10) @(negedge clk);
    check_reset_values("after_stale");
    lat_cfg = 1;
    play(0, 'h50, 2, 'h100, 0);
    play(0, 'h50, 0, 'h100, 0);
    play(1, 'h50, 0, 'h100, 0);
    stall_cfg = -1;
    lat_cfg = -1;

    // Randomized playback, including base addresses that wrap the address space.
    for (int r = 0; r < 14; r++) begin
      g = $urandom_range(0, 1);
      n = $urandom_range(1, 12);
      bse = $urandom_range(0, 255);
      if ($urandom_range(0, 2) == 0) bse = 'h7FFFF8 + $urandom_range(0, 7);
      play(g, bse, n, $urandom_range('h40, 'hFFF), $urandom_range(0, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
